// File: rtl/hpd_gen.sv
// Sink-side HPD line driver: holds HPD high while the sink is present, emits IRQ_HPD low pulses on request.
// Latency: outputs are registered from the next state, so they change one cycle after the deciding input is sampled.
// Backpressure: irq_req is a level held until irq_ack; requests wait while unplugged, mid-pulse or inside the spacing window.
//
// Ports:
//   clk, rst          - single clock, synchronous active-high reset
//   sink_present      - level, 1 = sink wants to be connected
//   irq_req           - IRQ request, held until irq_ack
//   hpd_signal        - registered HPD line drive (high only in ON)
//   irq_ack           - one-cycle pulse, the IRQ low pulse starts this cycle
//   irq_done          - one-cycle pulse, the line returned high after a full IRQ pulse
//   connected         - 1 while in ON or IRQ_LOW
module hpd_gen #(
    parameter int CLK_FREQ          = 100_000,
    parameter int IRQ_WIDTH_TICKS   = 75,
    parameter int IRQ_SPACING_TICKS = 200,
    parameter int UNPLUG_MIN_TICKS  = 10_000
) (
    input  logic clk,
    input  logic rst,
    input  logic sink_present,
    input  logic irq_req,
    output logic hpd_signal,
    output logic irq_ack,
    output logic irq_done,
    output logic connected
);

    localparam int MS_TICKS = CLK_FREQ / 1000;

    localparam int OFF_W = (UNPLUG_MIN_TICKS  > 1) ? $clog2(UNPLUG_MIN_TICKS)  : 1;
    localparam int SP_W  = (IRQ_SPACING_TICKS > 1) ? $clog2(IRQ_SPACING_TICKS) : 1;
    localparam int PW_W  = (IRQ_WIDTH_TICKS   > 1) ? $clog2(IRQ_WIDTH_TICKS)   : 1;

    localparam logic [OFF_W-1:0] OFF_MAX = OFF_W'(UNPLUG_MIN_TICKS - 1);
    localparam logic [SP_W-1:0]  SP_MAX  = SP_W'(IRQ_SPACING_TICKS - 1);
    localparam logic [PW_W-1:0]  PW_MAX  = PW_W'(IRQ_WIDTH_TICKS - 1);

    // The remote detector only classifies a low pulse of 0.5..1 ms as an IRQ.
    if (IRQ_WIDTH_TICKS < MS_TICKS / 2 || IRQ_WIDTH_TICKS > MS_TICKS || IRQ_WIDTH_TICKS < 1) begin : g_bad_width
        $error("hpd_gen: IRQ_WIDTH_TICKS outside MS_TICKS/2 .. MS_TICKS");
    end

    typedef enum logic [1:0] {
        OFF     = 2'd0,
        ON      = 2'd1,
        IRQ_LOW = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [OFF_W-1:0]   off_cnt, off_nxt;
    logic [SP_W-1:0]    sp_cnt, sp_nxt;
    logic [PW_W-1:0]    pw_cnt, pw_nxt;
    logic               ack_nxt, done_nxt;

    always_comb begin
        state_nxt = state;
        off_nxt   = off_cnt;
        sp_nxt    = sp_cnt;
        pw_nxt    = pw_cnt;
        ack_nxt   = 1'b0;
        done_nxt  = 1'b0;

        case (state)
            OFF: begin
                off_nxt = (off_cnt == OFF_MAX) ? off_cnt : off_cnt + 1'b1;
                if (sink_present && off_cnt >= OFF_MAX) begin
                    state_nxt = ON;
                    sp_nxt    = '0;
                end
            end
            ON: begin
                sp_nxt = (sp_cnt == SP_MAX) ? sp_cnt : sp_cnt + 1'b1;
                // Unplug beats a simultaneous request; the request stays pending.
                if (!sink_present) begin
                    state_nxt = OFF;
                    off_nxt   = '0;
                end else if (irq_req && sp_cnt >= SP_MAX) begin
                    state_nxt = IRQ_LOW;
                    pw_nxt    = '0;
                    ack_nxt   = 1'b1;
                end
            end
            IRQ_LOW: begin
                pw_nxt = (pw_cnt == PW_MAX) ? pw_cnt : pw_cnt + 1'b1;
                // Unplug aborts the pulse silently; the unplug low time restarts from zero.
                if (!sink_present) begin
                    state_nxt = OFF;
                    off_nxt   = '0;
                end else if (pw_cnt == PW_MAX) begin
                    state_nxt = ON;
                    sp_nxt    = '0;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = OFF;
                off_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= OFF;
            // Saturated so a present sink connects on the first cycle after reset.
            off_cnt    <= OFF_MAX;
            sp_cnt     <= '0;
            pw_cnt     <= '0;
            hpd_signal <= 1'b0;
            irq_ack    <= 1'b0;
            irq_done   <= 1'b0;
            connected  <= 1'b0;
        end else begin
            state      <= state_nxt;
            off_cnt    <= off_nxt;
            sp_cnt     <= sp_nxt;
            pw_cnt     <= pw_nxt;
            hpd_signal <= (state_nxt == ON);
            irq_ack    <= ack_nxt;
            irq_done   <= done_nxt;
            connected  <= (state_nxt != OFF);
        end
    end

endmodule

// File: tb/tb_hpd_gen.sv
// Self-checking bench for hpd_gen with default parameters (75 / 200 / 10_000 ticks).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_hpd_gen;

    logic clk = 1'b0;
    logic rst;
    logic sink_present;
    logic irq_req;
    logic hpd_signal;
    logic irq_ack;
    logic irq_done;
    logic connected;

    int total = 0;
    int bad   = 0;

    hpd_gen dut (
        .clk          (clk),
        .rst          (rst),
        .sink_present (sink_present),
        .irq_req      (irq_req),
        .hpd_signal   (hpd_signal),
        .irq_ack      (irq_ack),
        .irq_done     (irq_done),
        .connected    (connected)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst;
        logic sink;
        logic req;
        logic hpd;
        logic ack;
        logic done;
        logic conn;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Counts falling edges on which hpd_signal equals level, starting with the current one.
    task automatic count_while(input logic level, input int budget,
                               output int n, output int acks, output int dones);
        n = 0;
        acks = 0;
        dones = 0;
        while (hpd_signal === level && n < budget) begin
            n++;
            if (irq_ack)  acks++;
            if (irq_done) dones++;
            @(negedge clk);
        end
        if (n >= budget) begin
            total++;
            bad++;
            $display("FAIL timeout: hpd_signal stuck at %0b for %0d cycles, required change within budget", level, n);
        end
    endtask

    initial begin
        int  n, a, d;
        bit  ok;

        rst = 1'b1;
        sink_present = 1'b0;
        irq_req = 1'b0;

        //            rst   sink  req   hpd   ack   done  conn
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // request while unplugged waits
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1}; // immediate connect after reset
        vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1}; // spacing not yet met
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // unplug beats request
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // unplug minimum holds line low
        vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1}; // reset re-arms immediate connect

        for (int i = 0; i < 9; i++) begin
            rst          = vecs[i].rst;
            sink_present = vecs[i].sink;
            irq_req      = vecs[i].req;
            @(negedge clk);
            chk($sformatf("vec%0d hpd", i),  int'(hpd_signal), int'(vecs[i].hpd));
            chk($sformatf("vec%0d ack", i),  int'(irq_ack),    int'(vecs[i].ack));
            chk($sformatf("vec%0d done", i), int'(irq_done),   int'(vecs[i].done));
            chk($sformatf("vec%0d conn", i), int'(connected),  int'(vecs[i].conn));
        end

        // Single IRQ after 300 connected cycles.
        irq_req = 1'b0;
        ok = 1'b1;
        repeat (300) begin
            @(negedge clk);
            if (hpd_signal !== 1'b1 || irq_ack !== 1'b0 || irq_done !== 1'b0) ok = 1'b0;
        end
        chk("single hold high", int'(ok), 1);
        irq_req = 1'b1;
        @(negedge clk);
        chk("single ack", int'(irq_ack), 1);
        chk("single ack low", int'(hpd_signal), 0);
        irq_req = 1'b0;
        count_while(1'b0, 1000, n, a, d);
        chk("single width", n, 75);
        chk("single acks in pulse", a, 1);
        chk("single done", int'(irq_done), 1);
        ok = 1'b1;
        repeat (300) begin
            @(negedge clk);
            if (hpd_signal !== 1'b1 || irq_ack !== 1'b0 || irq_done !== 1'b0) ok = 1'b0;
        end
        chk("single no more pulses", int'(ok), 1);

        // Back-to-back IRQs with request held through three acks.
        irq_req = 1'b1;
        @(negedge clk);
        for (int p = 0; p < 3; p++) begin
            chk($sformatf("b2b ack%0d", p), int'(irq_ack), 1);
            if (p == 2) irq_req = 1'b0;
            count_while(1'b0, 1000, n, a, d);
            chk($sformatf("b2b width%0d", p), n, 75);
            chk($sformatf("b2b done%0d", p), int'(irq_done), 1);
            if (p < 2) begin
                count_while(1'b1, 1000, n, a, d);
                chk($sformatf("b2b spacing%0d", p), n, 200);
            end
        end

        // Request raised 50 cycles after irq_done must still wait for the full spacing.
        ok = 1'b1;
        repeat (49) begin
            @(negedge clk);
            if (irq_ack !== 1'b0) ok = 1'b0;
        end
        chk("spacing early no ack", int'(ok), 1);
        irq_req = 1'b1;
        @(negedge clk);
        count_while(1'b1, 1000, n, a, d);
        chk("spacing late request", 50 + n, 200);
        chk("spacing ack", int'(irq_ack), 1);
        irq_req = 1'b0;
        count_while(1'b0, 1000, n, a, d);
        chk("spacing width", n, 75);

        // Unplug at pw_cnt = 30, replug after 5 cycles, request pending during OFF.
        irq_req = 1'b1;
        count_while(1'b1, 1000, n, a, d);
        chk("unplug pre ack", int'(irq_ack), 1);
        irq_req = 1'b0;
        ok = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (hpd_signal !== 1'b0 || irq_done !== 1'b0) ok = 1'b0;
        end
        chk("unplug pulse running", int'(ok), 1);
        sink_present = 1'b0;
        @(negedge clk);
        chk("unplug connected", int'(connected), 0);
        chk("unplug no done", int'(irq_done), 0);
        repeat (4) @(negedge clk);
        sink_present = 1'b1;
        irq_req = 1'b1;
        @(negedge clk);
        count_while(1'b0, 20000, n, a, d);
        chk("unplug low time", 5 + n, 10000);
        chk("unplug acks in off", a, 0);
        chk("unplug dones in off", d, 0);
        chk("replug connected", int'(connected), 1);
        count_while(1'b1, 1000, n, a, d);
        chk("replug spacing", n, 200);
        chk("replug ack", int'(irq_ack), 1);
        irq_req = 1'b0;

        // Reset at pw_cnt = 40 with the sink still present.
        repeat (40) @(negedge clk);
        chk("reset pre low", int'(hpd_signal), 0);
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk($sformatf("rst%0d outputs", c),
                int'({hpd_signal, irq_ack, irq_done, connected}), 0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("post rst hpd", int'(hpd_signal), 1);
        chk("post rst conn", int'(connected), 1);
        chk("post rst done", int'(irq_done), 0);
        ok = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (irq_done !== 1'b0 || irq_ack !== 1'b0 || hpd_signal !== 1'b1) ok = 1'b0;
        end
        chk("post rst quiet", int'(ok), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
